ast_mux: RTL and testbench

- Avalon-ST packet multiplexer: merges TX_DIR input streams into one output stream.
- Arbitration is round-robin and packet-granular. A grant is locked from the accepted startofpacket beat until the accepted endofpacket beat.
- Sits upstream of ast_dmx: it is the opposite-direction counterpart. The output channel field carries the source index, so ast_dmx can route on it.

---
 rtl/ast_mux_pkg.sv | 39 +++
 rtl/ast_rr_arbiter.sv | 26 ++
 rtl/ast_mux.sv | 132 +++++++++++++
 tb/tb_ast_mux.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ast_mux_pkg.sv
// Shared types and the round-robin search helper for the Avalon-ST packet mux.
//   state_t    : arbitration FSM states
//   grant_t    : arbiter result (found flag + winner index)
//   next_grant : first requester after rr_last, searching rr_last+1, rr_last+2, ... mod n
package ast_mux_pkg;

  localparam int unsigned MAX_DIR       = 32;
  localparam int unsigned MAX_SEL_WIDTH = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic                     found;
    logic [MAX_SEL_WIDTH-1:0] idx;
  } grant_t;

  // n is the number of live requesters (<= MAX_DIR); rr_last must be < n.
  function automatic grant_t next_grant(input logic [MAX_DIR-1:0] valid_sop,
                                        input int unsigned         rr_last,
                                        input int unsigned         n);
    grant_t      g;
    int unsigned k;
    g = '0;
    for (int unsigned i = 1; i <= MAX_DIR; i++) begin
      // rr_last + i stays below 2n, so one subtraction is a full wrap.
      k = rr_last + i;
      if (k >= n) k = k - n;
      if ((i <= n) && !g.found && valid_sop[k[MAX_SEL_WIDTH-1:0]]) begin
        g.found = 1'b1;
        g.idx   = k[MAX_SEL_WIDTH-1:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/ast_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i     : per-input request (valid & startofpacket)
//   rr_last_i : index of the previous winner
//   grant_o   : winning index (meaningful when found_o=1)
//   found_o   : at least one request present
module ast_rr_arbiter
  import ast_mux_pkg::*;
#(
  parameter int unsigned TX_DIR        = 4,
  parameter int unsigned DIR_SEL_WIDTH = $clog2(TX_DIR)
) (
  input  logic [TX_DIR-1:0]        req_i,
  input  logic [DIR_SEL_WIDTH-1:0] rr_last_i,
  output logic [DIR_SEL_WIDTH-1:0] grant_o,
  output logic                     found_o
);

  grant_t pick;

  always_comb begin
    pick    = next_grant(MAX_DIR'(req_i), 32'(rr_last_i), TX_DIR);
    grant_o = DIR_SEL_WIDTH'(pick.idx);
    found_o = pick.found;
  end

endmodule

// File: rtl/ast_mux.sv
// Avalon-ST packet multiplexer: merges TX_DIR input streams into one output,
// round-robin per packet, with the source index carried on ast_channel_o.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   ast_*_i [TX_DIR]       : input streams (data/sop/eop/valid/empty)
//   ast_ready_o [TX_DIR]   : per-input ready, only the granted input can see 1
//   ast_*_o                : registered output beat plus source channel
//   ast_ready_i            : downstream ready
module ast_mux
  import ast_mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned TX_DIR        = 4,
  parameter int unsigned DIR_SEL_WIDTH = $clog2(TX_DIR)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [TX_DIR-1:0][DATA_WIDTH-1:0]    ast_data_i,
  input  logic [TX_DIR-1:0]                    ast_startofpacket_i,
  input  logic [TX_DIR-1:0]                    ast_endofpacket_i,
  input  logic [TX_DIR-1:0]                    ast_valid_i,
  input  logic [TX_DIR-1:0][EMPTY_WIDTH-1:0]   ast_empty_i,
  output logic [TX_DIR-1:0]                    ast_ready_o,
  output logic [DATA_WIDTH-1:0]                ast_data_o,
  output logic                                 ast_startofpacket_o,
  output logic                                 ast_endofpacket_o,
  output logic                                 ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]               ast_empty_o,
  output logic [CHANNEL_WIDTH-1:0]             ast_channel_o,
  input  logic                                 ast_ready_i
);

  state_t                     state_q, state_d;
  logic [DIR_SEL_WIDTH-1:0]   grant_q, grant_d;
  logic [DIR_SEL_WIDTH-1:0]   rr_last_q, rr_last_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic                       sop_q, sop_d;
  logic                       eop_q, eop_d;
  logic                       valid_q, valid_d;
  logic [EMPTY_WIDTH-1:0]     empty_q, empty_d;
  logic [CHANNEL_WIDTH-1:0]   chan_q, chan_d;

  logic [TX_DIR-1:0]          ready_c;
  logic [DIR_SEL_WIDTH-1:0]   arb_grant;
  logic                       arb_found;

  // Only packet starts compete; a stray non-sop beat in IDLE stays stalled.
  ast_rr_arbiter #(
    .TX_DIR        (TX_DIR),
    .DIR_SEL_WIDTH (DIR_SEL_WIDTH)
  ) u_arb (
    .req_i     (ast_valid_i & ast_startofpacket_i),
    .rr_last_i (rr_last_q),
    .grant_o   (arb_grant),
    .found_o   (arb_found)
  );

  // State register and output beat register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_last_q <= DIR_SEL_WIDTH'(TX_DIR - 1);
      data_q    <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      valid_q   <= 1'b0;
      empty_q   <= '0;
      chan_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      data_q    <= data_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      valid_q   <= valid_d;
      empty_q   <= empty_d;
      chan_q    <= chan_d;
    end
  end

  // Next-state: arbitrate in IDLE, forward the granted stream while LOCKED.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    data_d    = data_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    valid_d   = valid_q;
    empty_d   = empty_q;
    chan_d    = chan_q;
    ready_c   = '0;

    // Drain first; a load below overrides it for back-to-back beats.
    if (valid_q && ast_ready_i) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d   = arb_grant;
          rr_last_d = arb_grant;
          state_d   = LOCKED;
        end
      end
      LOCKED: begin
        ready_c[grant_q] = ~valid_q | ast_ready_i;
        if (ast_valid_i[grant_q] && ready_c[grant_q]) begin
          data_d  = ast_data_i[grant_q];
          sop_d   = ast_startofpacket_i[grant_q];
          eop_d   = ast_endofpacket_i[grant_q];
          empty_d = ast_empty_i[grant_q];
          chan_d  = CHANNEL_WIDTH'(grant_q);
          valid_d = 1'b1;
          if (ast_endofpacket_i[grant_q]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ast_ready_o         = ready_c;
  assign ast_data_o          = data_q;
  assign ast_startofpacket_o = sop_q;
  assign ast_endofpacket_o   = eop_q;
  assign ast_valid_o         = valid_q;
  assign ast_empty_o         = empty_q;
  assign ast_channel_o       = chan_q;

endmodule

// File: tb/tb_ast_mux.sv
// Scoreboard bench for ast_mux: per-input source queues drive the streams,
// accepted input beats are pushed as expected output beats, and a separate
// monitor pops and compares on every output handshake.
module tb_ast_mux;

  localparam int unsigned DW = 64;
  localparam int unsigned EW = 3;
  localparam int unsigned CW = 8;
  localparam int unsigned TX = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  typedef struct packed {
    beat_t         b;
    logic [CW-1:0] ch;
  } exp_t;

  typedef enum int {
    MUX_ONE_BYTE, MUX_RR_FAIRNESS, MUX_BACKPRESSURE, MUX_LOCK,
    MUX_RESET_MID_PACKET, MUX_NON_SOP, MUX_RANDOM
  } test_case_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [TX-1:0][DW-1:0]    data_i;
  logic [TX-1:0]            sop_i, eop_i, valid_i;
  logic [TX-1:0][EW-1:0]    empty_i;
  logic [TX-1:0]            ready_o;
  logic [DW-1:0]            data_o;
  logic                     sop_o, eop_o, valid_o;
  logic [EW-1:0]            empty_o;
  logic [CW-1:0]            ch_o;
  logic                     rdy_i;

  ast_mux #(
    .DATA_WIDTH    (DW),
    .CHANNEL_WIDTH (CW),
    .TX_DIR        (TX)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .ast_data_i          (data_i),
    .ast_startofpacket_i (sop_i),
    .ast_endofpacket_i   (eop_i),
    .ast_valid_i         (valid_i),
    .ast_empty_i         (empty_i),
    .ast_ready_o         (ready_o),
    .ast_data_o          (data_o),
    .ast_startofpacket_o (sop_o),
    .ast_endofpacket_o   (eop_o),
    .ast_valid_o         (valid_o),
    .ast_empty_o         (empty_o),
    .ast_channel_o       (ch_o),
    .ast_ready_i         (rdy_i)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  beat_t       src_q[TX][$];
  exp_t        sb_q[$];
  logic [TX-1:0] showing;
  int          valid_pct, ready_pct;

  // Reference arbitration model: who owns the output, and the last winner.
  logic        m_busy;
  int          m_owner, m_last;

  int          out_sop_ch[$];
  int          last_eop_cyc, last_gap, first_out_cyc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [TX-1:0] cand, input int last);
    for (int d = 1; d <= int'(TX); d++)
      if (cand[(last + d) % TX]) return (last + d) % TX;
    return -1;
  endfunction

  task automatic add_pkt(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data  = {$urandom, $urandom};
      b.sop   = (k == 0);
      b.eop   = (k == len - 1);
      b.empty = EW'($urandom_range(0, 7));
      src_q[src].push_back(b);
    end
  endtask

  // One clock: drive at negedge, sample handshakes just before posedge.
  task automatic step();
    logic [TX-1:0] acc, cand, allowed;
    beat_t b;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < int'(TX); i++) begin
      if (!showing[i] && src_q[i].size() > 0 && $urandom_range(0, 99) < valid_pct)
        showing[i] = 1'b1;
      if (showing[i]) begin
        b = src_q[i][0];
        data_i[i]  = b.data;
        sop_i[i]   = b.sop;
        eop_i[i]   = b.eop;
        empty_i[i] = b.empty;
        valid_i[i] = 1'b1;
      end else begin
        data_i[i]  = '0;
        sop_i[i]   = 1'b0;
        eop_i[i]   = 1'b0;
        empty_i[i] = '0;
        valid_i[i] = 1'b0;
      end
    end
    rdy_i = ($urandom_range(0, 99) < ready_pct);
    #4;
    acc     = valid_i & ready_o;
    cand    = valid_i & sop_i;
    allowed = m_busy ? TX'(1 << m_owner) : '0;
    check("ready_leak", 128'(ready_o & ~allowed), 128'(0));
    if (acc != '0) begin
      for (int i = 0; i < int'(TX); i++) begin
        if (acc[i]) begin
          check("grant_owner", 128'(i), m_busy ? 128'(m_owner) : '1);
          b = src_q[i].pop_front();
          showing[i] = 1'b0;
          sb_q.push_back('{b: b, ch: CW'(i)});
          if (b.eop) m_busy = 1'b0;
        end
      end
    end else if (!m_busy && cand != '0) begin
      m_owner = rr_pick(cand, m_last);
      m_last  = m_owner;
      m_busy  = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (n < limit) begin
      if (sb_q.size() == 0 && showing == '0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
          src_q[2].size() == 0 && src_q[3].size() == 0) break;
      step();
      n++;
    end
    if (n >= limit) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d beats still expected after %0d cycles", sb_q.size(), limit);
      for (int i = 0; i < int'(TX); i++) src_q[i].delete();
      sb_q.delete();
      showing = '0;
    end
    repeat (3) step();
  endtask

  // Output monitor: pops the scoreboard on handshakes, checks stall stability.
  logic          prev_stall = 1'b0;
  logic [76:0]   held;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall)
        check("stall_stable", 128'({valid_o, data_o, sop_o, eop_o, empty_o, ch_o}), 128'({1'b1, held}));
      if (valid_o && first_out_cyc < 0) first_out_cyc = cyc;
      if (valid_o && rdy_i) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got ch=%0d data=%0h with nothing expected", ch_o, data_o);
        end else begin
          e = sb_q.pop_front();
          check("out_beat", 128'({data_o, sop_o, eop_o, empty_o, ch_o}), 128'(e));
        end
        if (sop_o) begin
          out_sop_ch.push_back(int'(ch_o));
          last_gap = cyc - last_eop_cyc;
        end
        if (eop_o) last_eop_cyc = cyc;
      end
      prev_stall = valid_o && !rdy_i;
      held       = {data_o, sop_o, eop_o, empty_o, ch_o};
    end
  end

  task automatic check_outputs_zero(input string name);
    check(name, 128'({ready_o, valid_o, data_o, sop_o, eop_o, empty_o, ch_o}), 128'(0));
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(TX); i++) src_q[i].delete();
    sb_q.delete();
    showing = '0;
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = TX - 1;
  endtask

  task automatic run_test(input test_case_t tc);
    beat_t b;
    int    t0, start;
    case (tc)
      MUX_ONE_BYTE: begin
        valid_pct = 100; ready_pct = 100;
        b.data = 64'hA5; b.sop = 1'b1; b.eop = 1'b1; b.empty = 3'd3;
        src_q[2].push_back(b);
        first_out_cyc = -1;
        t0 = cyc + 1;
        drain(50);
        check("one_byte_latency", 128'(first_out_cyc - t0), 128'(2));
      end
      MUX_RR_FAIRNESS: begin
        valid_pct = 100; ready_pct = 100;
        out_sop_ch.delete();
        start = m_last;
        for (int p = 0; p < 3; p++)
          for (int i = 0; i < int'(TX); i++) add_pkt(i, 3);
        drain(500);
        check("rr_count", 128'(out_sop_ch.size()), 128'(12));
        for (int k = 0; k < out_sop_ch.size(); k++)
          check("rr_order", 128'(out_sop_ch[k]), 128'((start + 1 + k) % TX));
      end
      MUX_BACKPRESSURE: begin
        valid_pct = 100; ready_pct = 50;
        for (int p = 0; p < 3; p++) add_pkt(1, 5);
        drain(500);
      end
      MUX_LOCK: begin
        valid_pct = 100; ready_pct = 100;
        out_sop_ch.delete();
        add_pkt(0, 4);
        step();
        step();
        add_pkt(3, 3);
        drain(200);
        check("lock_gap", 128'(last_gap), 128'(2));
        check("lock_order", 128'(out_sop_ch.size() == 2 ? out_sop_ch[0] * 10 + out_sop_ch[1] : -1),
              128'(3));
      end
      MUX_RESET_MID_PACKET: begin
        valid_pct = 100; ready_pct = 100;
        add_pkt(2, 4);
        repeat (3) step();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_zero("reset_async_outputs");
        model_reset();
        valid_i = '0; sop_i = '0; eop_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_sop_ch.delete();
        add_pkt(3, 2); add_pkt(1, 2); add_pkt(2, 2); add_pkt(0, 2);
        drain(200);
        check("reset_first_winner", 128'(out_sop_ch.size() > 0 ? out_sop_ch[0] : -1), 128'(0));
      end
      MUX_NON_SOP: begin
        valid_pct = 100; ready_pct = 100;
        b.data = 64'h1234; b.sop = 1'b0; b.eop = 1'b0; b.empty = '0;
        src_q[1].push_back(b);
        repeat (6) begin
          step();
          #1 check("nonsop_no_output", 128'({valid_o, ready_o}), 128'(0));
        end
        src_q[1].delete();
        showing[1] = 1'b0;
        repeat (2) step();
      end
      MUX_RANDOM: begin
        valid_pct = 70; ready_pct = 60;
        for (int p = 0; p < 40; p++) add_pkt($urandom_range(0, TX - 1), $urandom_range(1, 6));
        drain(5000);
      end
      default: ;
    endcase
  endtask

  initial begin
    rst = 1'b1;
    data_i = '0; sop_i = '0; eop_i = '0; valid_i = '0; empty_i = '0;
    rdy_i = 1'b0;
    last_eop_cyc = 0; last_gap = 0; first_out_cyc = -1;
    model_reset();
    #12;
    check_outputs_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    run_test(MUX_RR_FAIRNESS);
    run_test(MUX_ONE_BYTE);
    run_test(MUX_BACKPRESSURE);
    run_test(MUX_LOCK);
    run_test(MUX_NON_SOP);
    run_test(MUX_RESET_MID_PACKET);
    run_test(MUX_RANDOM);
    run_test(MUX_RR_FAIRNESS);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
